// File: rtl/seg_static_drv.sv
// Static 7-segment driver: one hex count shown on every digit at once.
// Optional macro SEG_DP_BLINK_EN makes dp toggle on each accepted tick.
module seg_static_drv #(
    parameter logic [3:0] MAX_VAL   = 4'd15,
    parameter int         SEL_WIDTH = 6
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 add_flag,
    input  logic                 hold_req,
    input  logic                 clr_req,
    output logic [SEL_WIDTH-1:0] sel,
    output logic [7:0]           seg_led,
    output logic                 wrap_flag
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [4:0] MAX_EXT = {1'b0, MAX_VAL};

    state_t     state_q;
    state_t     state_d;
    logic       adv;
    logic [3:0] cnt_val;
    logic [3:0] cnt_d;
    logic       wrap_d;
    logic [6:0] seg_d;
    logic       dp_bit;

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; add_flag is judged against the pre-toggle state
    always_comb begin
        state_d = state_q;
        adv     = 1'b0;
        case (state_q)
            RUN: begin
                adv = add_flag;
                if (hold_req) state_d = HOLD;
            end
            HOLD: begin
                if (hold_req) state_d = RUN;
            end
        endcase
    end

    // Next count: clear beats advance, wrap only on a real advance
    always_comb begin
        cnt_d  = cnt_val;
        wrap_d = 1'b0;
        if (clr_req) begin
            cnt_d = 4'd0;
        end else if (adv) begin
            if (cnt_val == MAX_VAL) begin
                cnt_d  = 4'd0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_val + 4'd1;
            end
        end
    end

    // Count register and registered wrap pulse
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_val   <= 4'd0;
            wrap_flag <= 1'b0;
        end else begin
            cnt_val   <= cnt_d;
            wrap_flag <= wrap_d;
        end
    end

`ifdef SEG_DP_BLINK_EN
    logic dp_reg;

    // dp toggles on every accepted advance, cleared with the count
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dp_reg <= 1'b0;
        end else if (clr_req) begin
            dp_reg <= 1'b0;
        end else if (adv) begin
            dp_reg <= ~dp_reg;
        end
    end

    assign dp_bit = ~dp_reg;
`else
    assign dp_bit = 1'b1;
`endif

    // Hex to active-low g..a; values beyond MAX_VAL show blank
    always_comb begin
        seg_d = 7'h7F;
        if ({1'b0, cnt_val} <= MAX_EXT) begin
            case (cnt_val)
                4'h0: seg_d = 7'h40;
                4'h1: seg_d = 7'h79;
                4'h2: seg_d = 7'h24;
                4'h3: seg_d = 7'h30;
                4'h4: seg_d = 7'h19;
                4'h5: seg_d = 7'h12;
                4'h6: seg_d = 7'h02;
                4'h7: seg_d = 7'h78;
                4'h8: seg_d = 7'h00;
                4'h9: seg_d = 7'h10;
                4'hA: seg_d = 7'h08;
                4'hB: seg_d = 7'h03;
                4'hC: seg_d = 7'h46;
                4'hD: seg_d = 7'h21;
                4'hE: seg_d = 7'h06;
                4'hF: seg_d = 7'h0E;
                default: seg_d = 7'h7F;
            endcase
        end
    end

    // Registered display outputs; all digits enabled once out of reset
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel     <= '1;
            seg_led <= 8'hFF;
        end else begin
            sel     <= '0;
            seg_led <= {dp_bit, seg_d};
        end
    end

endmodule

// File: tb/tb_seg_static_drv.sv
// Bench for seg_static_drv: cycle model plus directed literal checks.
// Honours SEG_DP_BLINK_EN the same way the design does.
module tb_seg_static_drv;

    localparam int SW   = 6;
    localparam int MAXV = 15;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b1;
    logic          add_flag  = 1'b0;
    logic          hold_req  = 1'b0;
    logic          clr_req   = 1'b0;
    logic [SW-1:0] sel;
    logic [7:0]    seg_led;
    logic          wrap_flag;

    int vectors     = 0;
    int miscompares = 0;
    int wrap_seen   = 0;
    bit chk_on      = 1'b0;

    logic [7:0] codes [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    int            m_cnt;
    bit            m_run;
    bit            m_dp;
    logic [7:0]    e_seg;
    logic [SW-1:0] e_sel;
    logic          e_wrap;

    seg_static_drv #(
        .MAX_VAL  (4'(MAXV)),
        .SEL_WIDTH(SW)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .add_flag (add_flag),
        .hold_req (hold_req),
        .clr_req  (clr_req),
        .sel      (sel),
        .seg_led  (seg_led),
        .wrap_flag(wrap_flag)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural model: what the outputs must show after each edge
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_cnt  = 0;
            m_run  = 1'b1;
            m_dp   = 1'b0;
            e_seg  = 8'hFF;
            e_sel  = '1;
            e_wrap = 1'b0;
        end else begin
            e_seg = codes[m_cnt];
`ifdef SEG_DP_BLINK_EN
            e_seg[7] = ~m_dp;
`endif
            e_sel  = '0;
            e_wrap = 1'b0;
            if (clr_req) begin
                m_cnt = 0;
                m_dp  = 1'b0;
            end else if (add_flag && m_run) begin
                if (m_cnt == MAXV) begin
                    m_cnt  = 0;
                    e_wrap = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
                m_dp = !m_dp;
            end
            if (hold_req) m_run = !m_run;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge sys_clk) begin
        if (chk_on) begin
            vectors++;
            if (seg_led !== e_seg || sel !== e_sel || wrap_flag !== e_wrap) begin
                miscompares++;
                $display("FAIL model t=%0t seg=%h want %h sel=%b want %b wrap=%b want %b",
                         $time, seg_led, e_seg, sel, e_sel, wrap_flag, e_wrap);
            end
            if (wrap_flag === 1'b1) wrap_seen++;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input logic a, input logic h, input logic c);
        add_flag = a;
        hold_req = h;
        clr_req  = c;
        @(posedge sys_clk);
        #1;
        add_flag = 1'b0;
        hold_req = 1'b0;
        clr_req  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        #1;
        chk("rst_seg", seg_led, 8'hFF);
        chk("rst_sel", 8'(sel), 8'(6'b111111));
        chk("rst_wrap", 8'(wrap_flag), 8'h00);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        idle(1);
        chk("rel_seg", seg_led, 8'hC0);
        chk("rel_sel", 8'(sel), 8'h00);
    endtask

    initial begin
        #2;
        chk_on = 1'b1;
        do_reset();

        // idle display after reset
        idle(10);
        chk("idle_seg", seg_led, 8'hC0);
        chk("idle_wrap", 8'(wrap_flag), 8'h00);

        // latency of first advance, then four more spaced pulses
        step(1, 0, 0);
        chk("lat1_seg", seg_led, 8'hC0);
        idle(1);
        chk("lat2_seg", seg_led, 8'hF9);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0);
            idle(3);
        end
        chk("five_seg", seg_led, 8'h92);

        // full count to F then wrap
        step(0, 0, 1);
        idle(2);
        wrap_seen = 0;
        for (int i = 0; i < 15; i++) step(1, 0, 0);
        idle(2);
        chk("cnt15_seg", seg_led, 8'h8E);
        step(1, 0, 0);
        chk("wrap_pulse", 8'(wrap_flag), 8'h01);
        idle(2);
        chk("wrap_seg", seg_led, 8'hC0);
        chk("wrap_once", 8'(wrap_seen), 8'h01);

        // hold ignores advances; coincident hold+add still counts
        step(0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        idle(2);
        chk("hold_seg", seg_led, 8'hF9);
        step(1, 1, 0);
        step(1, 0, 0);
        idle(2);
        chk("hold_coin_seg", seg_led, 8'hA4);
        step(0, 1, 0);

        // clear beats add at 15: no wrap, state stays RUN
        step(0, 0, 1);
        for (int i = 0; i < 15; i++) step(1, 0, 0);
        wrap_seen = 0;
        step(1, 0, 1);
        idle(2);
        chk("clr_seg", seg_led, 8'hC0);
        chk("clr_nowrap", 8'(wrap_seen), 8'h00);
        step(1, 0, 0);
        idle(2);
        chk("clr_run_seg", seg_led, 8'hF9);

        // reset while wrap_flag is high
        for (int i = 0; i < 14; i++) step(1, 0, 0);
        step(1, 0, 0);
        chk("pre_rst_wrap", 8'(wrap_flag), 8'h01);
        do_reset();
        chk("post_rst_wrap", 8'(wrap_flag), 8'h00);

        // reset while holding returns to RUN
        step(0, 1, 0);
        do_reset();
        step(1, 0, 0);
        idle(1);
        chk("rst_hold_seg", seg_led, 8'hF9);

`ifdef SEG_DP_BLINK_EN
        // dp blink and reset mid-sequence
        do_reset();
        chk("dp0", 8'(seg_led[7]), 8'h01);
        step(1, 0, 0);
        idle(1);
        chk("dp1", 8'(seg_led[7]), 8'h00);
        step(1, 0, 0);
        idle(1);
        chk("dp2", 8'(seg_led[7]), 8'h01);
        step(1, 0, 0);
        idle(1);
        chk("dp3", 8'(seg_led[7]), 8'h00);
        do_reset();
`endif

        idle(3);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
